// File: rtl/fpu_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// fpu_dispatch_pkg
// Shared encodings for the FP operation dispatcher: opcodes, unit indices,
// rounding-mode codes, sequencer state encoding, canonical NaN and the
// helper functions that classify and route a request.
// No ports (package). Configuration macro used by the top: FPU_FFLAGS_ACCUM_EN.
// ---------------------------------------------------------------------------
package fpu_dispatch_pkg;

    // Request opcodes; 5..7 are illegal
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd4;

    // Unit indices into unit_start / unit_done / unit_result / unit_flags
    localparam logic [1:0] U_ADD  = 2'd0;
    localparam logic [1:0] U_MUL  = 2'd1;
    localparam logic [1:0] U_DIV  = 2'd2;
    localparam logic [1:0] U_SQRT = 2'd3;

    // RISC-V rounding-mode codes
    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;
    localparam logic [2:0] DYN = 3'd7;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    // Bit position of NV inside {NV,DZ,OF,UF,NX}
    localparam int FLAG_NV = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Dynamic rounding takes fcsr.frm, otherwise the instruction field
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
        logic [2:0] res;
        if (rm == DYN) begin
            res = frm;
        end else begin
            res = rm;
        end
        return res;
    endfunction

    // Only RNE..RMM are executable modes after resolution
    function automatic logic rm_illegal(input logic [2:0] rm);
        logic bad;
        case (rm)
            RNE, RTZ, RDN, RUP, RMM: bad = 1'b0;
            default:                 bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        logic bad;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT: bad = 1'b0;
            default:                                bad = 1'b1;
        endcase
        return bad;
    endfunction

    // ADD and SUB share the adder; unit_sub distinguishes them
    function automatic logic [1:0] op_unit(input logic [2:0] op);
        logic [1:0] u;
        case (op)
            OP_ADD, OP_SUB: u = U_ADD;
            OP_MUL:         u = U_MUL;
            OP_DIV:         u = U_DIV;
            OP_SQRT:        u = U_SQRT;
            default:        u = U_ADD;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/fpu_done_watchdog.sv
// ---------------------------------------------------------------------------
// fpu_done_watchdog
// 8-bit wait counter for the dispatcher. Cleared while clr_i is high, counts
// while en_i is high. expired_o is high during the LIMIT-th enabled cycle
// after a clear, so an enabled window lasts exactly LIMIT cycles.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear of the count
//   en_i        count enable (dispatcher in WAIT)
//   expired_o   LIMIT enabled cycles have elapsed including this one
// ---------------------------------------------------------------------------
module fpu_done_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins, saturate instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/fpu_op_dispatch.sv
// ---------------------------------------------------------------------------
// fpu_op_dispatch
// Single-issue sequencer between the FP execute stage and the multi-cycle SP
// units. IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one operation in flight.
// Illegal opcode / rounding mode skips straight to RESP without starting a unit.
// A unit that does not signal done within DONE_TIMEOUT WAIT cycles is abandoned
// and a canonical NaN with NV is returned, flagged by rsp_timeout.
// All outputs are registered.
// Ports:
//   req_*       request channel (valid/ready, op, operands, rm, tag), frm = fcsr.frm
//   unit_*      shared start/operand bus to the units, done/result/flags back
//   rsp_*       response channel to writeback (valid/ready)
//   fflags_acc  sticky flags, fflags_clr clears them
// Configuration macro FPU_FFLAGS_ACCUM_EN: when defined, fflags_acc accumulates
// rsp_flags at every response handshake; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module fpu_op_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int TAG_W        = 5,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [2:0]        req_rm,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [2:0]        frm,
    output logic [3:0]        unit_start,
    output logic [31:0]       unit_a,
    output logic [31:0]       unit_b,
    output logic [2:0]        unit_rm,
    output logic              unit_sub,
    input  logic [3:0]        unit_done,
    input  logic [127:0]      unit_result,
    input  logic [19:0]       unit_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_result,
    output logic [4:0]        rsp_flags,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_illegal,
    output logic              rsp_timeout,
    output logic [4:0]        fflags_acc,
    input  logic              fflags_clr
);

    state_e            state_q,       state_d;
    logic              req_ready_q,   req_ready_d;
    logic [1:0]        sel_q,         sel_d;
    logic [3:0]        unit_start_q,  unit_start_d;
    logic [31:0]       unit_a_q,      unit_a_d;
    logic [31:0]       unit_b_q,      unit_b_d;
    logic [2:0]        unit_rm_q,     unit_rm_d;
    logic              unit_sub_q,    unit_sub_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [31:0]       rsp_result_q,  rsp_result_d;
    logic [4:0]        rsp_flags_q,   rsp_flags_d;
    logic [TAG_W-1:0]  rsp_tag_q,     rsp_tag_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic              accept_s;
    logic [2:0]        rm_res_s;
    logic              expired_s;
    logic [3:0][31:0]  res_slices_s;
    logic [3:0][4:0]   flag_slices_s;

    assign accept_s      = req_valid && req_ready_q;
    assign rm_res_s      = resolve_rm(req_rm, frm);
    assign res_slices_s  = unit_result;
    assign flag_slices_s = unit_flags;

    // Counter is cleared during ISSUE so it reads zero on WAIT entry
    fpu_done_watchdog #(
        .LIMIT (DONE_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ST_ISSUE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (expired_s)
    );

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        unit_start_d  = 4'b0000;
        unit_a_d      = unit_a_q;
        unit_b_d      = unit_b_q;
        unit_rm_d     = unit_rm_q;
        unit_sub_d    = unit_sub_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_illegal_d = rsp_illegal_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    rsp_tag_d = req_tag;
                    if (op_illegal(req_op) || rm_illegal(rm_res_s)) begin
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_result_d  = 32'h0000_0000;
                        rsp_flags_d   = 5'b00000;
                        rsp_illegal_d = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d      = ST_ISSUE;
                        sel_d        = op_unit(req_op);
                        unit_start_d = 4'b0001 << op_unit(req_op);
                        unit_a_d     = req_a;
                        unit_b_d     = req_b;
                        unit_rm_d    = rm_res_s;
                        unit_sub_d   = (req_op == OP_SUB);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // done is not sampled here: a unit needs at least one cycle
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            // Only the selected unit's done counts; done beats expiry in the last cycle
            ST_WAIT: begin
                if (unit_done[sel_q]) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = res_slices_s[sel_q];
                    rsp_flags_d   = flag_slices_s[sel_q];
                    rsp_illegal_d = 1'b0;
                    rsp_timeout_d = 1'b0;
                end else if (expired_s) begin
                    state_d              = ST_RESP;
                    rsp_valid_d          = 1'b1;
                    rsp_result_d         = CANON_NAN;
                    rsp_flags_d          = 5'b00000;
                    rsp_flags_d[FLAG_NV] = 1'b1;
                    rsp_illegal_d        = 1'b0;
                    rsp_timeout_d        = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // Sequencer state and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            sel_q         <= U_ADD;
            unit_start_q  <= 4'b0000;
            unit_a_q      <= 32'h0000_0000;
            unit_b_q      <= 32'h0000_0000;
            unit_rm_q     <= 3'b000;
            unit_sub_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 32'h0000_0000;
            rsp_flags_q   <= 5'b00000;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            sel_q         <= sel_d;
            unit_start_q  <= unit_start_d;
            unit_a_q      <= unit_a_d;
            unit_b_q      <= unit_b_d;
            unit_rm_q     <= unit_rm_d;
            unit_sub_q    <= unit_sub_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

`ifdef FPU_FFLAGS_ACCUM_EN
    logic [4:0] acc_q;
    logic [4:0] acc_d;
    logic       rsp_hs_s;

    assign rsp_hs_s = rsp_valid_q && rsp_ready;

    // Sticky flags: a clear coinciding with a handshake keeps that response's flags
    always_comb begin
        acc_d = acc_q;
        if (fflags_clr) begin
            if (rsp_hs_s) begin
                acc_d = rsp_flags_q;
            end else begin
                acc_d = 5'b00000;
            end
        end else if (rsp_hs_s) begin
            acc_d = acc_q | rsp_flags_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 5'b00000;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign fflags_acc = acc_q;
`else
    // Writeback accumulates flags itself in this build
    logic unused_fflags_clr_s;
    assign unused_fflags_clr_s = fflags_clr;
    assign fflags_acc          = 5'b00000;
`endif

    assign req_ready   = req_ready_q;
    assign unit_start  = unit_start_q;
    assign unit_a      = unit_a_q;
    assign unit_b      = unit_b_q;
    assign unit_rm     = unit_rm_q;
    assign unit_sub    = unit_sub_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_illegal = rsp_illegal_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_dispatch
// Table-driven bench for fpu_op_dispatch with DONE_TIMEOUT=8. Each table row
// holds one request, the behaviour of the emulated unit and the expected
// response; expected responses go through a scoreboard queue. Hand-written
// sequences cover reset and an asynchronous reset in the middle of WAIT.
// ---------------------------------------------------------------------------
module tb_fpu_op_dispatch;

    localparam int TAG_W = 5;
    localparam int TO    = 8;
    localparam logic [127:0] BG_RES = {4{32'hBADB_AD00}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic [2:0]        req_rm;
    logic [TAG_W-1:0]  req_tag;
    logic [2:0]        frm;
    logic [3:0]        unit_start;
    logic [31:0]       unit_a;
    logic [31:0]       unit_b;
    logic [2:0]        unit_rm;
    logic              unit_sub;
    logic [3:0]        unit_done;
    logic [127:0]      unit_result;
    logic [19:0]       unit_flags;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic [4:0]        rsp_flags;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_illegal;
    logic              rsp_timeout;
    logic [4:0]        fflags_acc;
    logic              fflags_clr;

    fpu_op_dispatch #(
        .TAG_W        (TAG_W),
        .DONE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_rm      (req_rm),
        .req_tag     (req_tag),
        .frm         (frm),
        .unit_start  (unit_start),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_rm     (unit_rm),
        .unit_sub    (unit_sub),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .unit_flags  (unit_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_tag     (rsp_tag),
        .rsp_illegal (rsp_illegal),
        .rsp_timeout (rsp_timeout),
        .fflags_acc  (fflags_acc),
        .fflags_clr  (fflags_clr)
    );

    always #5 clk = ~clk;

    // dly: cycles after the start cycle when the unit pulses done (0 = never)
    // spur_off: cycles after start when a non-selected done bit pulses (0 = none)
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [2:0]  frm;
        logic [4:0]  tag;
        int          dly;
        logic [31:0] ures;
        logic [4:0]  uflg;
        int          spur_bit;
        int          spur_off;
        int          hold;
        bit          clr;
        logic [31:0] x_res;
        logic [4:0]  x_flg;
        bit          x_ill;
        bit          x_to;
        logic [3:0]  x_start;
        logic [2:0]  x_rm;
        bit          x_sub;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        logic [4:0]  tag;
        bit          ill;
        bit          to;
        int          lat;
    } exp_t;

    vec_t       vecs[11];
    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [4:0] acc_m  = 5'b00000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"},   {31'd0, req_ready},   32'd1);
        chk({pfx, "_unit_start"},  {28'd0, unit_start},  32'd0);
        chk({pfx, "_rsp_valid"},   {31'd0, rsp_valid},   32'd0);
        chk({pfx, "_rsp_result"},  rsp_result,           32'd0);
        chk({pfx, "_rsp_flags"},   {27'd0, rsp_flags},   32'd0);
        chk({pfx, "_rsp_tag"},     {27'd0, rsp_tag},     32'd0);
        chk({pfx, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
        chk({pfx, "_rsp_timeout"}, {31'd0, rsp_timeout}, 32'd0);
        chk({pfx, "_unit_a"},      unit_a,               32'd0);
        chk({pfx, "_unit_b"},      unit_b,               32'd0);
        chk({pfx, "_unit_rm"},     {29'd0, unit_rm},     32'd0);
        chk({pfx, "_unit_sub"},    {31'd0, unit_sub},    32'd0);
        chk({pfx, "_fflags_acc"},  {27'd0, fflags_acc},  32'd0);
    endtask

    // Applies one table row; entered and left on a negedge with the DUT idle
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   u;
        int   k;
        int   start_k;
        int   start_cnt;
        int   rsp_k;
        bit   hs;
        bit   finished;
        int   guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d_ready_before_req", idx), {31'd0, req_ready}, 32'd1);

        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_rm    = v.rm;
        req_tag   = v.tag;
        frm       = v.frm;
        e.res = v.x_res;
        e.flg = v.x_flg;
        e.tag = v.tag;
        e.ill = v.x_ill;
        e.to  = v.x_to;
        if (v.x_ill)     e.lat = 1;
        else if (v.x_to) e.lat = TO + 2;
        else             e.lat = v.dly + 2;
        sb_q.push_back(e);

        u = v.x_start[0] ? 0 : (v.x_start[1] ? 1 : (v.x_start[2] ? 2 : 3));
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'd7;
        req_a     = 32'hFFFF_FFFF;
        req_b     = 32'hFFFF_FFFF;
        frm       = 3'd5;

        k = 1; start_k = -1; start_cnt = 0; rsp_k = -1; hs = 1'b0; finished = 1'b0;
        while (!finished && k < 60) begin
            unit_done   = 4'b0000;
            unit_result = BG_RES;
            unit_flags  = 20'hFFFFF;
            if (unit_start != 4'b0000) begin
                start_cnt++;
                start_k = k;
                chk($sformatf("v%0d_unit_start", idx), {28'd0, unit_start}, {28'd0, v.x_start});
                chk($sformatf("v%0d_unit_rm", idx),    {29'd0, unit_rm},    {29'd0, v.x_rm});
                chk($sformatf("v%0d_unit_sub", idx),   {31'd0, unit_sub},   {31'd0, v.x_sub});
                chk($sformatf("v%0d_unit_a", idx),     unit_a,              v.a);
            end
            if (start_k >= 0 && v.dly > 0 && k == start_k + v.dly) begin
                unit_done[u]            = 1'b1;
                unit_result[u*32 +: 32] = v.ures;
                unit_flags[u*5 +: 5]    = v.uflg;
            end
            if (start_k >= 0 && v.spur_off > 0 && k == start_k + v.spur_off) begin
                unit_done[v.spur_bit] = 1'b1;
            end
            if (rsp_valid) begin
                if (rsp_k < 0) begin
                    rsp_k = k;
                    if (sb_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL v%0d_sb_empty: got response with nothing expected", idx);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("v%0d_latency", idx), k, e.lat);
                    end
                end
                chk($sformatf("v%0d_rsp_result", idx),  rsp_result,           e.res);
                chk($sformatf("v%0d_rsp_flags", idx),   {27'd0, rsp_flags},   {27'd0, e.flg});
                chk($sformatf("v%0d_rsp_tag", idx),     {27'd0, rsp_tag},     {27'd0, e.tag});
                chk($sformatf("v%0d_rsp_illegal", idx), {31'd0, rsp_illegal}, {31'd0, e.ill});
                chk($sformatf("v%0d_rsp_timeout", idx), {31'd0, rsp_timeout}, {31'd0, e.to});
                chk($sformatf("v%0d_ready_in_resp", idx), {31'd0, req_ready}, 32'd0);
                if (k - rsp_k >= v.hold) begin
                    rsp_ready  = 1'b1;
                    fflags_clr = v.clr;
                    hs         = 1'b1;
                end
            end
            @(negedge clk);
            if (hs) begin
                finished   = 1'b1;
                rsp_ready  = 1'b0;
                fflags_clr = 1'b0;
                unit_done  = 4'b0000;
`ifdef FPU_FFLAGS_ACCUM_EN
                if (v.clr) acc_m = e.flg;
                else       acc_m = acc_m | e.flg;
`endif
                chk($sformatf("v%0d_valid_after_hs", idx), {31'd0, rsp_valid}, 32'd0);
                chk($sformatf("v%0d_ready_after_hs", idx), {31'd0, req_ready}, 32'd1);
                chk($sformatf("v%0d_fflags_acc", idx), {27'd0, fflags_acc}, {27'd0, acc_m});
            end
            k++;
        end
        if (!finished) begin
            errors++;
            checks++;
            $display("FAIL v%0d_rsp_wait: no handshake within %0d cycles", idx, k);
            rsp_ready = 1'b0;
        end
        chk($sformatf("v%0d_start_cycles", idx), start_cnt, (v.x_start != 4'b0000) ? 1 : 0);
    endtask

    initial begin
        //            op    a             b             rm    frm   tag    dly ures          uflg      sb so hold clr  x_res         x_flg     ill to start    x_rm  sub
        vecs[0]  = '{3'd2, 32'h3FC00000, 32'h40000000, 3'd0, 3'd0, 5'd5,  4,  32'h40400000, 5'b00000, 0, 0, 0, 1'b0, 32'h40400000, 5'b00000, 0, 0, 4'b0010, 3'd0, 0};
        vecs[1]  = '{3'd4, 32'h40800000, 32'hDEADBEEF, 3'd7, 3'd1, 5'd9,  2,  32'h40000000, 5'b00001, 0, 0, 0, 1'b0, 32'h40000000, 5'b00001, 0, 0, 4'b1000, 3'd1, 0};
        vecs[2]  = '{3'd0, 32'h3F800000, 32'h3F800000, 3'd7, 3'd6, 5'd3,  2,  32'h12345678, 5'b00001, 0, 0, 0, 1'b0, 32'h00000000, 5'b00000, 1, 0, 4'b0000, 3'd0, 0};
        vecs[3]  = '{3'd7, 32'h3F800000, 32'h3F800000, 3'd0, 3'd0, 5'd4,  2,  32'h12345678, 5'b00001, 0, 0, 0, 1'b0, 32'h00000000, 5'b00000, 1, 0, 4'b0000, 3'd0, 0};
        vecs[4]  = '{3'd1, 32'h3F800000, 32'h3F800000, 3'd5, 3'd0, 5'd6,  2,  32'h12345678, 5'b00001, 0, 0, 2, 1'b0, 32'h00000000, 5'b00000, 1, 0, 4'b0000, 3'd0, 0};
        vecs[5]  = '{3'd3, 32'h3F800000, 32'h00000000, 3'd2, 3'd0, 5'd10, 0,  32'h00000000, 5'b00000, 0, 3, 0, 1'b0, 32'h7FC00000, 5'b10000, 0, 1, 4'b0100, 3'd2, 0};
        vecs[6]  = '{3'd3, 32'h00000001, 32'h00000002, 3'd3, 3'd0, 5'd11, 10, 32'h12345678, 5'b01000, 0, 0, 5, 1'b0, 32'h7FC00000, 5'b10000, 0, 1, 4'b0100, 3'd3, 0};
        vecs[7]  = '{3'd1, 32'h40000000, 32'h3F800000, 3'd7, 3'd4, 5'd31, 8,  32'h3F800000, 5'b00100, 0, 0, 1, 1'b1, 32'h3F800000, 5'b00100, 0, 0, 4'b0001, 3'd4, 1};
        vecs[8]  = '{3'd0, 32'h11111111, 32'h22222222, 3'd1, 3'd0, 5'd0,  1,  32'h33333333, 5'b00010, 1, 1, 0, 1'b0, 32'h33333333, 5'b00010, 0, 0, 4'b0001, 3'd1, 0};
        vecs[9]  = '{3'd3, 32'h3F800000, 32'h40400000, 3'd7, 3'd0, 5'd17, 3,  32'h3EAAAAAB, 5'b00001, 3, 2, 2, 1'b0, 32'h3EAAAAAB, 5'b00001, 0, 0, 4'b0100, 3'd0, 0};
        vecs[10] = '{3'd2, 32'h40000000, 32'hC0000000, 3'd4, 3'd0, 5'd22, 5,  32'hC0800000, 5'b00000, 0, 0, 0, 1'b0, 32'hC0800000, 5'b00000, 0, 0, 4'b0010, 3'd4, 0};

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 3'd0;
        req_a       = 32'h0;
        req_b       = 32'h0;
        req_rm      = 3'd0;
        req_tag     = 5'd0;
        frm         = 3'd0;
        unit_done   = 4'b0000;
        unit_result = BG_RES;
        unit_flags  = 20'hFFFFF;
        rsp_ready   = 1'b0;
        fflags_clr  = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset");

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Asynchronous reset while a DIV sits in WAIT
        req_valid = 1'b1;
        req_op    = 3'd3;
        req_a     = 32'h40A00000;
        req_b     = 32'h40000000;
        req_rm    = 3'd1;
        req_tag   = 5'd19;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midwait_start", {28'd0, unit_start}, 32'd4);
        repeat (3) @(negedge clk);
        chk("midwait_busy", {31'd0, req_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midwait_reset");
        acc_m = 5'b00000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("midwait_release");
        run_vec(99, vecs[0]);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
